// File: rtl/pw_retrieve_wrapper_if.sv
// Bus bundle for pw_retrieve_wrapper: request/response, record-memory read port and decrypt-core handshake.
// master = requester/memory/core side, slave = the wrapper.
interface pw_retrieve_wrapper_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 128
);
  logic              go;
  logic [DATA_W-1:0] master_key;
  logic [DATA_W-1:0] account;
  logic [ADDR_W-1:0] max_address;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_account;
  logic [DATA_W-1:0] mem_pw_enc;
  logic              dec_start;
  logic [DATA_W-1:0] dec_key;
  logic [DATA_W-1:0] dec_in;
  logic [DATA_W-1:0] dec_out;
  logic              dec_done;
  logic [DATA_W-1:0] password;
  logic              done;
  logic              found;
  logic              busy;
  logic              err;

  modport master (
    output go, master_key, account, max_address, mem_account, mem_pw_enc, dec_out, dec_done,
    input  mem_rd, mem_addr, dec_start, dec_key, dec_in, password, done, found, busy, err
  );
  modport slave (
    input  go, master_key, account, max_address, mem_account, mem_pw_enc, dec_out, dec_done,
    output mem_rd, mem_addr, dec_start, dec_key, dec_in, password, done, found, busy, err
  );
endinterface

// File: rtl/pw_retrieve_wrapper.sv
// Password retrieve path: linear scan of the record memory, then hand-off to the AES-128 decrypt core.
// Optional decrypt watchdog enabled by defining RETRIEVE_TIMEOUT_EN.
module pw_retrieve_wrapper #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 128,
  parameter int TIMEOUT_CYC = 64
) (
  input logic                   clk,
  input logic                   rst,
  pw_retrieve_wrapper_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, READ, CMP, DEC, WAIT, FIN} state_t;

  state_t            state, next;
  logic [ADDR_W-1:0] addr, max_q;
  logic [DATA_W-1:0] key_q, acc_q, ct_q, pw_q;
  logic              found_q, done_q, start_q;
  logic              hit, last, tmo, accept;

  assign accept = (state == IDLE) && bus.go;
  assign hit    = (bus.mem_account == acc_q);
  assign last   = (addr == max_q);

`ifdef RETRIEVE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  logic          err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tcnt <= '0;
    else if (state == WAIT) tcnt <= tcnt + 1'b1;
    else tcnt <= '0;
  end

  // a late answer on the final counted cycle still wins over the watchdog
  assign tmo = (state == WAIT) && !bus.dec_done && (tcnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else if (accept) err_q <= 1'b0;
    else if (tmo) err_q <= 1'b1;
  end
  assign bus.err = err_q;
`else
  assign tmo     = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: if (bus.go) next = READ;
      READ: next = CMP;
      CMP:  if (hit) next = DEC;
            else if (last) next = FIN;
            else next = READ;
      DEC:  next = WAIT;
      WAIT: if (bus.dec_done || tmo) next = FIN;
      FIN:  next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr    <= '0;
      max_q   <= '0;
      key_q   <= '0;
      acc_q   <= '0;
      ct_q    <= '0;
      pw_q    <= '0;
      found_q <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      // start/done are registered one cycle behind DEC/FIN
      start_q <= (state == DEC);
      done_q  <= (state == FIN);
      case (state)
        IDLE: if (bus.go) begin
          key_q   <= bus.master_key;
          acc_q   <= bus.account;
          max_q   <= bus.max_address;
          addr    <= '0;
          found_q <= 1'b0;
          pw_q    <= '0;
        end
        CMP: begin
          if (hit) ct_q <= bus.mem_pw_enc;
          else if (!last) addr <= addr + 1'b1;
          else begin
            found_q <= 1'b0;
            pw_q    <= '0;
          end
        end
        WAIT: begin
          if (bus.dec_done) begin
            pw_q    <= bus.dec_out;
            found_q <= 1'b1;
          end else if (tmo) begin
            found_q <= 1'b0;
            pw_q    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_rd    = (state == READ);
  assign bus.mem_addr  = (state == READ) ? addr : '0;
  assign bus.dec_start = start_q;
  assign bus.dec_key   = key_q;
  assign bus.dec_in    = ct_q;
  assign bus.password  = pw_q;
  assign bus.done      = done_q;
  assign bus.found     = found_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_pw_retrieve_wrapper.sv
// Directed + randomized bench for pw_retrieve_wrapper with behavioural record memory and decrypt core.
module tb_pw_retrieve_wrapper;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 128;
  localparam int TOUT   = 64;
  localparam logic [127:0] K_AES = 128'h5468617473206D79204B756E67204675;
  localparam logic [127:0] C_AES = 128'h29C3505F571420F6402299B31A02D73A;
  localparam logic [127:0] P_AES = 128'h54776F204F6E65204E696E652054776F;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pw_retrieve_wrapper_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  pw_retrieve_wrapper #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [127:0] mem_acc [16];
  logic [127:0] mem_pw  [16];
  int           rd_q [$];
  int           done_total = 0;
  int           core_lat = 0;
  bit           core_en = 1'b1;
  bit           stray = 1'b0;
  bit           core_busy;
  int           core_cnt;
  logic [127:0] core_ct, core_key;

  // Reference decrypt: the known AES vector, anything else a fixed scramble
  function automatic logic [127:0] core_fn(input logic [127:0] key, input logic [127:0] ct);
    if (key == K_AES && ct == C_AES) return P_AES;
    return ct ^ key ^ 128'h5A5A_0000_A5A5_0000_1234_5678_9ABC_DEF0;
  endfunction

  function automatic logic [127:0] rnd128();
    return {1'b1, 31'($urandom), $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (bus.mem_rd) begin
      bus.mem_account <= mem_acc[bus.mem_addr];
      bus.mem_pw_enc  <= mem_pw[bus.mem_addr];
      rd_q.push_back(int'(bus.mem_addr));
    end
    if (bus.done) done_total++;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.dec_done <= 1'b0;
      bus.dec_out  <= '0;
      core_busy    <= 1'b0;
      core_cnt     <= 0;
    end else begin
      bus.dec_done <= 1'b0;
      if (stray) begin
        bus.dec_done <= 1'b1;
        bus.dec_out  <= 128'hBAD0BAD0;
      end else if (bus.dec_start && core_en) begin
        core_busy <= 1'b1;
        core_cnt  <= core_lat;
        core_ct   <= bus.dec_in;
        core_key  <= bus.dec_key;
      end else if (core_busy) begin
        if (core_cnt == 0) begin
          bus.dec_done <= 1'b1;
          bus.dec_out  <= core_fn(core_key, core_ct);
          core_busy    <= 1'b0;
        end else core_cnt <= core_cnt - 1;
      end
    end
  end

  task automatic run(input string tag, input logic [127:0] key, input logic [127:0] acc,
                     input int maxa, input int lat, input bit noise);
    int exp_k, exp_done, exp_start, n, seen_done, seen_start, n_start, n_rd, dones0;
    logic [127:0] exp_pw;
    bit exp_found, exp_err, ok;
    exp_k = -1;
    for (int j = 0; j <= maxa; j++) if (exp_k < 0 && mem_acc[j] == acc) exp_k = j;
    exp_err   = 1'b0;
    exp_start = (exp_k < 0) ? -1 : 2 * exp_k + 3;
    exp_done  = (exp_k < 0) ? 2 * (maxa + 1) + 1 : 2 * exp_k + 7 + lat;
    exp_found = (exp_k >= 0);
    exp_pw    = (exp_k < 0) ? 128'h0 : core_fn(key, mem_pw[exp_k]);
    if (exp_k >= 0 && !core_en) begin
      exp_done  = 2 * exp_k + 4 + TOUT;
      exp_found = 1'b0;
      exp_pw    = '0;
      exp_err   = 1'b1;
    end
    core_lat = lat;
    rd_q.delete();
    dones0 = done_total;
    @(negedge clk);
    bus.go = 1'b1; bus.master_key = key; bus.account = acc; bus.max_address = 4'(maxa);
    n = -1; seen_done = -1; seen_start = -1; n_start = 0;
    while (seen_done < 0 && n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.dec_start) begin
        n_start++;
        if (seen_start < 0) begin
          seen_start = n;
          check({tag, "_dec_in"}, bus.dec_in, mem_pw[exp_k < 0 ? 0 : exp_k]);
          check({tag, "_dec_key"}, bus.dec_key, key);
        end
      end
      if (bus.done) begin
        seen_done = n;
        bus.go = 1'b0;
        check({tag, "_found"}, 128'(bus.found), 128'(exp_found));
        check({tag, "_password"}, bus.password, exp_pw);
        check({tag, "_err"}, 128'(bus.err), 128'(exp_err));
      end else begin
        bus.go = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noise) bus.account = rnd128();
      end
    end
    bus.go = 1'b0;
    check({tag, "_done_cycle"}, 128'(seen_done), 128'(exp_done));
    check({tag, "_start_cycle"}, 128'(seen_start), 128'(exp_start));
    check({tag, "_start_count"}, 128'(n_start), 128'(exp_k >= 0 ? 1 : 0));
    n_rd = (exp_k >= 0) ? exp_k + 1 : maxa + 1;
    ok = (rd_q.size() == n_rd);
    foreach (rd_q[i]) if (rd_q[i] != i) ok = 1'b0;
    check({tag, "_probes"}, 128'(ok), 128'(1));
    @(negedge clk);
    check({tag, "_done_pulse"}, 128'({bus.done, bus.busy}), 128'(0));
    check({tag, "_done_total"}, 128'(done_total - dones0), 128'(1));
  endtask

  initial begin
    logic [127:0] a;
    int k, m;
    bit ok;
    bus.go = 1'b0; bus.master_key = '0; bus.account = '0; bus.max_address = '0;
    for (int i = 0; i < 16; i++) begin
      mem_acc[i] = rnd128();
      mem_pw[i]  = rnd128();
    end
    #1;
    check("reset_outputs", {bus.mem_rd, bus.mem_addr, bus.dec_start, bus.done, bus.found,
                            bus.busy, bus.err}, 128'h0);
    check("reset_data", bus.password | bus.dec_in | bus.dec_key, 128'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    mem_acc[0] = 128'h0; mem_pw[0] = C_AES;
    run("hit0_aes", K_AES, 128'h0, 1, 2, 1'b0);
    mem_acc[0] = rnd128();

    run("miss_max3", K_AES, 128'h1, 3, 0, 1'b0);

    a = rnd128(); mem_acc[15] = a;
    run("hit_last", rnd128(), a, 15, 1, 1'b0);
    run("miss_max0", rnd128(), a, 0, 0, 1'b0);

    // abort mid-search: outputs clear at once, no done afterwards
    @(negedge clk);
    bus.go = 1'b1; bus.account = 128'h1; bus.max_address = 4'd15; bus.master_key = K_AES;
    @(negedge clk);
    bus.go = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_outputs", {bus.mem_rd, bus.mem_addr, bus.dec_start, bus.done, bus.found,
                            bus.busy, bus.err}, 128'h0);
    check("abort_data", bus.password | bus.dec_in | bus.dec_key, 128'h0);
    k = done_total;
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_done", 128'(done_total - k), 128'(0));

    // stray dec_done while idle
    k = done_total;
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.busy || bus.done) ok = 1'b0;
    end
    check("stray_dec_done", 128'({ok, 16'(done_total - k)}), 128'({1'b1, 16'd0}));

    a = rnd128(); mem_acc[5] = a; mem_acc[9] = a;
    run("first_match", rnd128(), a, 12, 0, 1'b1);
    mem_acc[5] = rnd128(); mem_acc[9] = rnd128();

    for (int it = 0; it < 12; it++) begin
      m = $urandom_range(0, 15);
      a = rnd128();
      if ($urandom_range(0, 2) != 0) begin
        k = $urandom_range(0, m);
        mem_acc[k] = a;
        mem_pw[k]  = rnd128();
      end else k = -1;
      run($sformatf("rnd%0d", it), rnd128(), a, m, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
      if (k >= 0) mem_acc[k] = rnd128();
    end

    // decrypt core never answers
    core_en = 1'b0;
    a = rnd128(); mem_acc[2] = a;
`ifdef RETRIEVE_TIMEOUT_EN
    run("timeout", rnd128(), a, 7, 0, 1'b0);
`else
    @(negedge clk);
    bus.go = 1'b1; bus.account = a; bus.max_address = 4'd7;
    @(negedge clk);
    bus.go = 1'b0;
    k = done_total;
    ok = 1'b1;
    repeat (150) begin
      @(negedge clk);
      if (!bus.busy) ok = 1'b0;
    end
    check("no_timeout_busy", 128'({ok, 16'(done_total - k)}), 128'({1'b1, 16'd0}));
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
`endif
    core_en = 1'b1;
    mem_acc[2] = rnd128();
    run("after_stall", rnd128(), 128'h1, 4, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
